// File: rtl/hilo_div_if.sv
// Command/result bundle between the pipeline and the HI/LO + divider unit.
interface hilo_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_hi;
    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, alu_hi, alu_lo,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, alu_hi, alu_lo,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/hilo_div_unit.sv
// Architectural HI/LO pair: multiply capture, mthi/mtlo, and a restoring
// iterative divider (div/divu) that takes WIDTH steps plus one sign-fix cycle.
module hilo_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    hilo_div_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] hi_q, hi_n;
    logic [WIDTH-1:0] lo_q, lo_n;
    logic [WIDTH-1:0] rem_q, rem_n;
    logic [WIDTH-1:0] quo_q, quo_n;
    logic [WIDTH-1:0] dvsr_q, dvsr_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             qneg_q, qneg_n;
    logic             rneg_q, rneg_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    logic             sgn;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Operand magnitudes; for divu the raw operands pass straight through
    assign sgn   = (bus.op == OP_DIV);
    assign abs_a = (sgn && bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
    assign abs_b = (sgn && bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvsr_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hi_q   <= '0;
            lo_q   <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            rem_q  <= rem_n;
            quo_q  <= quo_n;
            dvsr_q <= dvsr_n;
            cnt_q  <= cnt_n;
            qneg_q <= qneg_n;
            rneg_q <= rneg_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        hi_n    = hi_q;
        lo_n    = lo_q;
        rem_n   = rem_q;
        quo_n   = quo_q;
        dvsr_n  = dvsr_q;
        cnt_n   = cnt_q;
        qneg_n  = qneg_q;
        rneg_n  = rneg_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_LOAD: begin
                            hi_n = bus.alu_hi;
                            lo_n = bus.alu_lo;
                        end
                        OP_MTHI: hi_n = bus.a;
                        OP_MTLO: lo_n = bus.a;
                        OP_DIV, OP_DIVU: begin
                            if (bus.b == '0) begin
                                // Divide by zero resolves immediately, no iteration
                                lo_n   = '1;
                                hi_n   = bus.a;
                                done_n = 1'b1;
                            end else begin
                                rem_n   = '0;
                                quo_n   = abs_a;
                                dvsr_n  = abs_b;
                                qneg_n  = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                rneg_n  = sgn & bus.a[WIDTH-1];
                                cnt_n   = '0;
                                busy_n  = 1'b1;
                                state_n = DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DIV: begin
                if (diff[WIDTH]) begin
                    rem_n = rem_sh[WIDTH-1:0];
                    quo_n = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_n = diff[WIDTH-1:0];
                    quo_n = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_n = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                lo_n    = qneg_q ? WIDTH'(-quo_q) : quo_q;
                hi_n    = rneg_q ? WIDTH'(-rem_q) : rem_q;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: directed corner cases plus random commands
// against an arithmetic reference model of HI/LO.
module tb_hilo_div_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_div_if #(.WIDTH(W)) bus ();
    hilo_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int unsigned due;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           is_div;
    } exp_t;

    exp_t         q[$];
    int unsigned  cyc = 0;
    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [W-1:0] m_hi, m_lo;
    bit           win = 0;
    int unsigned  bs = 0, be = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_busy(input int unsigned c);
        return win && c >= bs && c <= be;
    endfunction

    // Reference: plain arithmetic, MIPS truncating semantics
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                    output logic [W-1:0] qv, output logic [W-1:0] rv);
        if (b == 0) begin
            qv = '1;
            rv = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            qv = 32'h8000_0000;
            rv = 0;
        end else if (sgn) begin
            qv = $signed(a) / $signed(b);
            rv = $signed(a) % $signed(b);
        end else begin
            qv = a / b;
            rv = a % b;
        end
    endfunction

    function automatic void push(input int unsigned due, input bit is_div);
        exp_t e;
        e.due = due;
        e.hi = m_hi;
        e.lo = m_lo;
        e.is_div = is_div;
        q.push_back(e);
    endfunction

    // Drives one command for one cycle (called at a negedge), updates the model
    task automatic cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ah, input logic [W-1:0] al);
        logic [W-1:0] qv, rv;
        bit acc;
        acc = !model_busy(cyc);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.alu_hi = ah;
        bus.alu_lo = al;
        if (acc) begin
            case (op)
                3'b001: begin m_hi = ah; m_lo = al; push(cyc + 1, 0); end
                3'b100: begin m_hi = a; push(cyc + 1, 0); end
                3'b101: begin m_lo = a; push(cyc + 1, 0); end
                3'b010, 3'b011: begin
                    ref_div(a, b, op == 3'b010, qv, rv);
                    m_lo = qv;
                    m_hi = rv;
                    if (b == 0) push(cyc + 1, 1);
                    else begin
                        push(cyc + 34, 1);
                        win = 1;
                        bs = cyc + 1;
                        be = cyc + 33;
                    end
                end
                default: ;
            endcase
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        while (model_busy(cyc)) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return W'($urandom_range(0, 20));
            1: return W'(-$signed(W'($urandom_range(1, 20))));
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares done/busy every cycle and HI/LO when an expectation falls due
    always @(negedge clk) begin
        if (!rst) begin
            bit exp_done;
            exp_t e;
            exp_done = (q.size() > 0) && q[0].due == cyc && q[0].is_div;
            if (bus.busy !== model_busy(cyc)) check("busy", W'(bus.busy), W'(model_busy(cyc)));
            if (bus.done || exp_done) check("done", W'(bus.done), W'(exp_done));
            if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check("due_cycle", cyc, e.due);
                check("hi", bus.hi, e.hi);
                check("lo", bus.lo, e.lo);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.alu_hi = 0; bus.alu_lo = 0;
        m_hi = 0; m_lo = 0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", W'(bus.busy), 0);
        check("rst_done", W'(bus.done), 0);
        rst = 1'b0;
        idle(2);

        // Reset during a division discards it
        cmd(3'b011, 100, 7, 0, 0);
        idle(9);
        q.delete();
        win = 0;
        m_hi = 0;
        m_lo = 0;
        rst = 1'b1;
        #1;
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_busy", W'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(40);

        // Directed divisions
        cmd(3'b011, 100, 7, 0, 0);                          wait_idle();
        cmd(3'b010, -32'sd7, 2, 0, 0);                      wait_idle();
        cmd(3'b010, 7, -32'sd2, 0, 0);                      wait_idle();
        cmd(3'b010, -32'sd7, -32'sd2, 0, 0);                wait_idle();
        cmd(3'b010, 32'h1234_5678, 0, 0, 0);                idle(2);
        cmd(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);    wait_idle();
        idle(1);

        // Multiply capture and moves
        cmd(3'b001, 0, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        cmd(3'b100, 5, 0, 0, 0);
        cmd(3'b101, 9, 0, 0, 0);
        idle(1);

        // Commands during busy are ignored; divu issued in the done cycle is accepted
        cmd(3'b011, 1000, 33, 0, 0);
        idle(4);
        cmd(3'b101, 32'hAAAA, 0, 0, 0);
        cmd(3'b001, 0, 0, 32'h1111_1111, 32'h2222_2222);
        wait_idle();
        cmd(3'b011, 50, 5, 0, 0);
        wait_idle();
        idle(2);

        // Random commands, including junk while busy and back-to-back issue
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            else cmd(3'($urandom_range(0, 7)), rnd_val(), ($urandom_range(0, 9) == 0) ? 0 : rnd_val(),
                     $urandom, $urandom);
        end
        wait_idle();
        idle(3);
        check("queue_drained", W'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
